// File: rtl/frame_cfg_pkg.sv
// Shared constants and state type for the configuration-frame initiator.
// Command words carry an opcode in the top nibble and a frame index in the low byte.
package frame_cfg_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_FRAME = 4'h1;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam int IDX_MSB = 7;
   localparam int IDX_LSB = 0;
   localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

   typedef enum logic [2:0] {
      IDLE,
      GET_DATA,
      SETUP,
      STROBE,
      HOLD
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/frame_cfg_writer.sv
// Turns a command/data word stream into FrameData plus a one-hot FrameStrobe
// with programmable setup/strobe/hold phasing for the tile config latches.
module frame_cfg_writer
   import frame_cfg_pkg::*;
#(
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20,
   parameter int SetupCycles     = 1,
   parameter int StrobeCycles    = 1,
   parameter int HoldCycles      = 1
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic [31:0]                s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic                       err_clr,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       busy,
   output logic                       err,
   output logic [15:0]                frames_written
);

   localparam int PHASE_MAX = max3(SetupCycles, StrobeCycles, HoldCycles);
   localparam int CW        = $clog2(PHASE_MAX + 1);
   localparam logic [CW-1:0] SETUP_LD  = CW'(SetupCycles - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(StrobeCycles - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'(HoldCycles - 1);

   state_t                     r_state;
   logic [CW-1:0]              r_cnt;
   logic [IDX_W-1:0]           r_idx;
   logic [FrameBitsPerRow-1:0] r_frame_data;
   logic [MaxFramesPerCol-1:0] r_strobe;
   logic                       r_ready;
   logic                       r_busy;
   logic                       r_err;
   logic [15:0]                r_frames_written;

   state_t                     w_state_next;
   logic [CW-1:0]              w_cnt_next;
   logic [IDX_W-1:0]           w_idx_next;
   logic [FrameBitsPerRow-1:0] w_data_next;
   logic [MaxFramesPerCol-1:0] w_strobe_next;
   logic                       w_err_set;
   logic                       w_err_next;
   logic [15:0]                w_fw_next;

   logic                       w_xfer;
   logic [3:0]                 w_opcode;
   logic                       w_in_range;
   logic [MaxFramesPerCol-1:0] w_onehot;

   assign w_xfer     = s_valid & r_ready;
   assign w_opcode   = s_data[OPC_MSB:OPC_LSB];
   assign w_in_range = 32'(r_idx) < 32'(MaxFramesPerCol);
   assign w_onehot   = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << r_idx;
   assign w_err_next = w_err_set ? 1'b1 : (err_clr ? 1'b0 : r_err);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state          <= IDLE;
         r_cnt            <= '0;
         r_idx            <= '0;
         r_frame_data     <= '0;
         r_strobe         <= '0;
         r_ready          <= 1'b0;
         r_busy           <= 1'b0;
         r_err            <= 1'b0;
         r_frames_written <= '0;
      end else begin
         r_state          <= w_state_next;
         r_cnt            <= w_cnt_next;
         r_idx            <= w_idx_next;
         r_frame_data     <= w_data_next;
         r_strobe         <= w_strobe_next;
         r_ready          <= (w_state_next == IDLE) || (w_state_next == GET_DATA);
         r_busy           <= (w_state_next != IDLE);
         r_err            <= w_err_next;
         r_frames_written <= w_fw_next;
      end
   end

   // Next values of the registered outputs; the strobe register is set only
   // while the next state is STROBE so it can never overlap a data change.
   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_idx_next    = r_idx;
      w_data_next   = r_frame_data;
      w_strobe_next = '0;
      w_err_set     = 1'b0;
      w_fw_next     = r_frames_written;
      case (r_state)
         IDLE: begin
            if (w_xfer) begin
               if (w_opcode == OP_FRAME) begin
                  w_idx_next   = s_data[IDX_MSB:IDX_LSB];
                  w_state_next = GET_DATA;
               end else if (w_opcode != OP_NOP) begin
                  w_err_set = 1'b1;
               end
            end
         end
         GET_DATA: begin
            if (w_xfer) begin
               if (w_in_range) begin
                  w_data_next  = s_data[FrameBitsPerRow-1:0];
                  w_cnt_next   = SETUP_LD;
                  w_state_next = SETUP;
               end else begin
                  w_err_set    = 1'b1;
                  w_state_next = IDLE;
               end
            end
         end
         SETUP: begin
            if (r_cnt == '0) begin
               w_cnt_next    = STROBE_LD;
               w_strobe_next = w_onehot;
               w_state_next  = STROBE;
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         STROBE: begin
            if (r_cnt == '0) begin
               w_cnt_next   = HOLD_LD;
               w_fw_next    = r_frames_written + 16'd1;
               w_state_next = HOLD;
            end else begin
               w_cnt_next    = r_cnt - CW'(1);
               w_strobe_next = w_onehot;
            end
         end
         HOLD: begin
            if (r_cnt == '0) begin
               w_data_next  = '0;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign s_ready        = r_ready;
   assign FrameData      = r_frame_data;
   assign FrameStrobe    = r_strobe;
   assign busy           = r_busy;
   assign err            = r_err;
   assign frames_written = r_frames_written;

endmodule

// File: tb/tb_frame_cfg_writer.sv
// Randomized bench for frame_cfg_writer: two instances (1/1/1 and 2/3/2 phasing)
// compared every cycle against a window-based reference model.
module tb_frame_cfg_writer;

   localparam int MF = 20;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        err_clr = 1'b0;
   logic        sel = 1'b0;

   logic        a_ready, b_ready, a_busy, b_busy, a_err, b_err;
   logic [31:0] a_data, b_data;
   logic [19:0] a_strobe, b_strobe;
   logic [15:0] a_fw, b_fw;

   logic        o_ready, o_busy, o_err;
   logic [31:0] o_data;
   logic [19:0] o_strobe;
   logic [15:0] o_fw;

   always #5 CLK = ~CLK;

   frame_cfg_writer #(
      .FrameBitsPerRow(32), .MaxFramesPerCol(MF),
      .SetupCycles(1), .StrobeCycles(1), .HoldCycles(1)
   ) dut_a (
      .CLK(CLK), .reset(reset), .s_data(s_data), .s_valid(s_valid & ~sel),
      .s_ready(a_ready), .err_clr(err_clr), .FrameData(a_data),
      .FrameStrobe(a_strobe), .busy(a_busy), .err(a_err), .frames_written(a_fw)
   );

   frame_cfg_writer #(
      .FrameBitsPerRow(32), .MaxFramesPerCol(MF),
      .SetupCycles(2), .StrobeCycles(3), .HoldCycles(2)
   ) dut_b (
      .CLK(CLK), .reset(reset), .s_data(s_data), .s_valid(s_valid & sel),
      .s_ready(b_ready), .err_clr(err_clr), .FrameData(b_data),
      .FrameStrobe(b_strobe), .busy(b_busy), .err(b_err), .frames_written(b_fw)
   );

   assign o_ready  = sel ? b_ready  : a_ready;
   assign o_busy   = sel ? b_busy   : a_busy;
   assign o_err    = sel ? b_err    : a_err;
   assign o_data   = sel ? b_data   : a_data;
   assign o_strobe = sel ? b_strobe : a_strobe;
   assign o_fw     = sel ? b_fw     : a_fw;

   int          n_vec = 0;
   int          n_err = 0;
   int          S = 1, St = 1, H = 1;
   int          e;
   int          m_T;
   bit          m_rdy, m_wait, m_active, m_err;
   logic [7:0]  m_idx;
   logic [31:0] m_d;
   logic [15:0] m_fw;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rdy = 0; m_wait = 0; m_active = 0; m_err = 0; m_fw = '0; e = 0; m_T = 0;
   endtask

   // A frame whose data transferred at edge T occupies offsets 0..S+St+H-1,
   // strobing at offsets S..S+St-1.
   task automatic check_outputs();
      int          o;
      logic [31:0] ed;
      logic [19:0] es;
      ed = '0;
      es = '0;
      if (m_active) begin
         o  = e - m_T;
         ed = m_d;
         if (o >= S && o < S + St) es = 20'd1 << m_idx;
      end
      chk("FrameData", o_data, ed);
      chk("FrameStrobe", 32'(o_strobe), 32'(es));
      chk("s_ready", 32'(o_ready), 32'(m_rdy && !m_active));
      chk("busy", 32'(o_busy), 32'(m_active || m_wait));
      chk("err", 32'(o_err), 32'(m_err));
      chk("frames_written", 32'(o_fw), 32'(m_fw));
   endtask

   task automatic model_edge(input bit v, input logic [31:0] d, input bit clr);
      bit nerr;
      nerr = 0;
      e++;
      if (v && m_rdy && !m_active) begin
         if (!m_wait) begin
            if (d[31:28] == 4'h1) begin
               m_wait = 1;
               m_idx  = d[7:0];
            end else if (d[31:28] != 4'h0) begin
               nerr = 1;
            end
            $display("dut%0d edge %0d command %h", sel, e, d);
         end else begin
            m_wait = 0;
            if (int'(m_idx) < MF) begin
               m_active = 1;
               m_T      = e;
               m_d      = d;
            end else begin
               nerr = 1;
            end
            $display("dut%0d edge %0d data %h idx %0d", sel, e, d, m_idx);
         end
      end else if (m_active) begin
         if (e - m_T == S + St) m_fw = m_fw + 16'd1;
         if (e - m_T == S + St + H) m_active = 0;
      end
      m_err = nerr ? 1'b1 : (clr ? 1'b0 : m_err);
      m_rdy = 1;
   endtask

   task automatic cycle(input bit v, input logic [31:0] d, input bit clr);
      s_valid = v;
      s_data  = d;
      err_clr = clr;
      @(posedge CLK);
      model_edge(v, d, clr);
      @(negedge CLK);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0);
   endtask

   task automatic send(input logic [31:0] w, input bit clr);
      int k;
      k = 0;
      while (!(m_rdy && !m_active) && k < 64) begin
         cycle(1'b0, $urandom, 1'b0);
         k++;
      end
      if (k >= 64) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: got busy expected ready within 64 cycles");
      end
      cycle(1'b1, w, clr);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      s_valid = 1'b0;
      err_clr = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge CLK);
      @(negedge CLK);
      reset = 1'b0;
   endtask

   function automatic logic [31:0] frame_cmd(input logic [7:0] idx);
      return {4'h1, 20'($urandom), idx};
   endfunction

   task automatic rand_run(input int n);
      int          kind;
      logic [31:0] w;
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(0, 2));
         kind = $urandom_range(0, 9);
         if (kind <= 1) begin
            send({4'h0, 28'($urandom)}, ($urandom_range(0, 7) == 0));
         end else if (kind <= 7) begin
            if (kind == 7) send(frame_cmd(8'($urandom_range(MF, 255))), 1'b0);
            else           send(frame_cmd(8'($urandom_range(0, MF - 1))), 1'b0);
            idle($urandom_range(0, 2));
            w = $urandom;
            send(w, ($urandom_range(0, 7) == 0));
         end else begin
            send({4'($urandom_range(2, 15)), 28'($urandom)}, ($urandom_range(0, 3) == 0));
         end
      end
      idle(8);
   endtask

   initial begin
      @(negedge CLK);
      sel = 1'b0; S = 1; St = 1; H = 1;
      do_reset();

      send(frame_cmd(8'd3), 1'b0);
      send(32'hDEADBEEF, 1'b0);
      idle(4);
      chk("first_frame_count", 32'(o_fw), 32'd1);

      send(frame_cmd(8'd0), 1'b0);
      send(32'h0000_0001, 1'b0);
      send(frame_cmd(8'd19), 1'b0);
      send(32'hFFFF_FFFF, 1'b0);
      idle(5);
      chk("back_to_back_count", 32'(o_fw), 32'd3);

      send(frame_cmd(8'd20), 1'b0);
      send(32'h1234_5678, 1'b0);
      chk("bad_idx_err", 32'(o_err), 32'd1);
      chk("bad_idx_data", o_data, 32'd0);
      send(32'h7000_0000, 1'b1);
      chk("err_wins_over_clr", 32'(o_err), 32'd1);
      cycle(1'b0, 32'h0, 1'b1);
      chk("err_clr_alone", 32'(o_err), 32'd0);

      send(frame_cmd(8'd5), 1'b0);
      send(32'hA5A5_5A5A, 1'b0);
      for (int k = 0; k < 20 && !(m_active && (e - m_T == S)); k++) cycle(1'b0, $urandom, 1'b0);
      chk("pre_reset_strobe", 32'(o_strobe), 32'h0000_0020);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("async_reset_strobe", 32'(o_strobe), 32'd0);
      chk("async_reset_data", o_data, 32'd0);
      check_outputs();
      @(negedge CLK);
      reset = 1'b0;
      send(frame_cmd(8'd2), 1'b0);
      send(32'hCAFE_F00D, 1'b0);
      idle(4);
      chk("after_reset_count", 32'(o_fw), 32'd1);

      force dut_a.r_frames_written = 16'hFFFF;
      #1 release dut_a.r_frames_written;
      m_fw = 16'hFFFF;
      send(frame_cmd(8'd11), 1'b0);
      send(32'h0BAD_CAFE, 1'b0);
      idle(4);
      chk("count_wrap", 32'(o_fw), 32'd0);

      rand_run(150);

      sel = 1'b1; S = 2; St = 3; H = 2;
      do_reset();
      send(frame_cmd(8'd7), 1'b0);
      send(32'h1357_9BDF, 1'b0);
      idle(8);
      chk("long_phase_count", 32'(o_fw), 32'd1);
      rand_run(150);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/frame_cfg_writer.md
Name: frame_cfg_writer

Overview:
- Initiator side of the fabric configuration-frame interface. Tile columns only buffer and forward this interface; this block generates it.
- Accepts a 32-bit command/data word stream over a valid/ready handshake (from the bitstream loader).
- Drives one row's FrameData bus and one column's one-hot FrameStrobe bus with programmable setup/strobe/hold phasing, so the tile config latches capture each frame.
- Sits between the bitstream loader and the bottom/top terminal tile of a fabric column.

Parameters:
- FrameBitsPerRow, 32, width of FrameData; fixed at 32, equal to the stream word width.
- MaxFramesPerCol, 20, width of FrameStrobe; legal frame indices are 0..MaxFramesPerCol-1.
- SetupCycles, 1, cycles FrameData is stable before the strobe; must be >=1.
- StrobeCycles, 1, cycles the FrameStrobe bit is high; must be >=1.
- HoldCycles, 1, cycles FrameData is held after the strobe drops; must be >=1.

Ports:
- CLK  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- s_data  input  32  command or data word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  block accepts s_data this cycle.
- err_clr  input  1  clears the sticky err flag.
- FrameData  output  FrameBitsPerRow  frame data to the tile row chain.
- FrameStrobe  output  MaxFramesPerCol  one-hot frame write strobe.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky protocol error.
- frames_written  output  16  count of completed strobes; wraps 0xFFFF->0.

Behaviour:
- Reset (async, active-high):
  - State=IDLE.
  - FrameData=0, FrameStrobe=0, err=0, frames_written=0, busy=0.
  - s_ready=1 on the first clock after reset deasserts; held 0 while reset is asserted.
- Handshake: a word transfers on a rising edge with s_valid&&s_ready. s_ready is 1 only in IDLE and GET_DATA. s_data may change freely when not transferring.
- Command word fields:
  - [31:28] opcode: 0x0=NOP, 0x1=FRAME, all others illegal.
  - [7:0] frame index, FRAME opcode only.
  - Remaining bits are ignored.
- All outputs are registered. The state machine:
  - IDLE:
    - NOP -> stay in IDLE.
    - FRAME -> latch index, go to GET_DATA.
    - Illegal opcode -> err<=1, stay in IDLE.
  - GET_DATA: on data transfer, latch the word into FrameData.
    - Index in range -> go to SETUP.
    - Index >= MaxFramesPerCol -> err<=1, FrameData stays 0, return to IDLE. The word is consumed and no strobe is issued.
  - SETUP: SetupCycles cycles, FrameStrobe=0.
  - STROBE: StrobeCycles cycles, FrameStrobe=1<<index. On the last cycle, frames_written increments.
  - HOLD: HoldCycles cycles, FrameStrobe=0, FrameData held. Exit -> IDLE with FrameData<=0.
- Timing, data transferring at edge T with defaults 1/1/1:
  - FrameData valid cycles T+1..T+3.
  - FrameStrobe high in cycle T+2 only.
  - FrameData=0 and s_ready=1 in cycle T+4.
  - General case: back in IDLE after SetupCycles+StrobeCycles+HoldCycles cycles.
- Minimum spacing: one command cycle + one data cycle + the phase cycles. Back-to-back frames need no idle gap beyond that.
- FrameStrobe is never multi-hot and is never high while FrameData changes. FrameData changes only on entry to SETUP and on exit from HOLD.
- Phase counter: width $clog2(max(SetupCycles,StrobeCycles,HoldCycles)+1). Reloads on every phase entry.
- err:
  - Sticky. err_clr clears it.
  - If err_clr and a new error occur in the same cycle, err=1 (the error wins).
  - err does not block operation.
- Reset mid-frame (any state): outputs return to reset values immediately and asynchronously, FrameStrobe included. The partial frame is discarded and frames_written is cleared.
- s_valid is ignored outside IDLE/GET_DATA. No word is lost, because s_ready=0 in those states.

Decomposition:
- Package frame_cfg_pkg holds:
  - opcode constants OP_NOP=4'h0 and OP_FRAME=4'h1;
  - field position constants;
  - the state enum {IDLE, GET_DATA, SETUP, STROBE, HOLD}.
- Single module. The phase down-counter stays inline; no sub-module.

Test Plan:
- Reset, then FRAME idx=3 followed by data 0xDEADBEEF, no stalls -> FrameData=0xDEADBEEF for 3 cycles, FrameStrobe=0x00008 for 1 cycle (middle), frames_written=1, then FrameData=0 and s_ready=1.
- Two back-to-back frames: idx=0/0x1 then idx=19/0xFFFFFFFF -> strobes 0x00001 then 0x80000, never overlapping; FrameData is stable across each strobe; frames_written=2.
- Bad index 20 with data 0x12345678, then opcode 0x7 -> no strobe, FrameData stays 0, err=1 after the first error; err_clr pulse in the same cycle as a new error leaves err=1; a later err_clr alone gives err=0.
- SetupCycles=2, StrobeCycles=3, HoldCycles=2 with random s_valid gaps and NOPs interleaved -> strobe width exactly 3, FrameData set 2 cycles before strobe and held 2 cycles after; NOPs produce no strobe.
- Assert reset during STROBE with idx=5 -> FrameStrobe and FrameData are 0 in the same cycle (async), state IDLE, frames_written=0; the next frame completes normally.
- Preload frames_written=0xFFFF by running 65535 frames (or via a force in the bench), run one more frame -> count wraps to 0x0000.
